player_motion: RTL and testbench

Frame-rate game-logic stage that feeds the VGA drawing stage. Once per video frame it moves the player square from button or tilt input, clamps it to the screen, and detects overlap with the target square. On a hit it counts score and relocates the target pseudo-randomly. Its 32-bit coordinate outputs connect directly to the drawing stage's player and target centre inputs.

---
 rtl/player_motion.sv | 203 ++++++++++++++++++++
 tb/tb_player_motion.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/player_motion.sv
// player_motion: once per frame moves the player square, clamps it to the
// screen, detects overlap with the target, scores hits and relocates the
// target with a 16-bit LFSR (fallback position after MAX_TRIES rejections).
// Ports: clk_25mHz, reset (sync, active-high), frame_tick, BTNU/BTNL/BTNR/BTND,
//   accel_x/accel_y (signed tilt), player_x/y, target_x/y (32-bit, zero-ext),
//   score (16-bit, wraps), hit (1-cycle pulse), busy (FSM not IDLE).
// Build option: define TILT_CONTROL_EN to steer from accel_x/accel_y instead
//   of the buttons.
module player_motion #(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int PLAYER_HALF = 25,
  parameter int TARGET_HALF = 30,
  parameter int BTN_STEP    = 4,
  parameter int TILT_SHIFT  = 4,
  parameter int MAX_STEP    = 8,
  parameter int MAX_TRIES   = 16
) (
  input  logic        clk_25mHz,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        BTNU,
  input  logic        BTNL,
  input  logic        BTNR,
  input  logic        BTND,
  input  logic [31:0] accel_x,
  input  logic [31:0] accel_y,
  output logic [31:0] player_x,
  output logic [31:0] player_y,
  output logic [31:0] target_x,
  output logic [31:0] target_y,
  output logic [15:0] score,
  output logic        hit,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE, MOVE, CHECK, RELOCATE
  } state_t;

  localparam int TW = $clog2(MAX_TRIES + 1);

  localparam logic signed [11:0] XLO = 12'(PLAYER_HALF);
  localparam logic signed [11:0] XHI = 12'(WIDTH - 1 - PLAYER_HALF);
  localparam logic signed [11:0] YHI = 12'(HEIGHT - 1 - PLAYER_HALF);
  localparam logic signed [11:0] SPAN = 12'(PLAYER_HALF + TARGET_HALF);
  localparam logic signed [11:0] BSTEP = 12'(BTN_STEP);

  localparam logic [9:0] TLO  = 10'(TARGET_HALF);
  localparam logic [9:0] TXHI = 10'(WIDTH - 1 - TARGET_HALF);
  localparam logic [9:0] TYHI = 10'(HEIGHT - 1 - TARGET_HALF);
  localparam logic [9:0] XMID = 10'(WIDTH / 2);
  localparam logic [9:0] YMID = 10'(HEIGHT / 2);

  state_t state, next;

  logic [9:0]    px, py, tx, ty;
  logic [15:0]   lfsr;
  logic [TW-1:0] tries;

  logic signed [11:0] dx, dy;
  logic [9:0]         nx, ny;
  logic [9:0]         cx, cy, fx, fy;
  logic               overlap, accept, give_up;
  logic [15:0]        lfsr_nx;

  function automatic logic [9:0] clamp(
    input logic signed [11:0] v,
    input logic signed [11:0] lo,
    input logic signed [11:0] hi
  );
    logic signed [11:0] r;
    r = v;
    if (v < lo) r = lo;
    else if (v > hi) r = hi;
    return r[9:0];
  endfunction

  function automatic logic near(
    input logic [9:0] a,
    input logic [9:0] b
  );
    logic signed [11:0] d;
    d = $signed({2'b00, a}) - $signed({2'b00, b});
    if (d < 0) d = -d;
    return d < SPAN;
  endfunction

`ifdef TILT_CONTROL_EN
  logic signed [31:0] ax, ay;
  logic unused_btn;
  assign unused_btn = ^{BTNU, BTNL, BTNR, BTND};

  always_comb begin
    ax = $signed(accel_x) >>> TILT_SHIFT;
    ay = $signed(accel_y) >>> TILT_SHIFT;
    if (ax > MAX_STEP) dx = 12'(MAX_STEP);
    else if (ax < -MAX_STEP) dx = -12'(MAX_STEP);
    else dx = 12'(ax);
    if (ay > MAX_STEP) dy = 12'(MAX_STEP);
    else if (ay < -MAX_STEP) dy = -12'(MAX_STEP);
    else dy = 12'(ay);
  end
`else
  logic unused_accel;
  assign unused_accel = ^{accel_x, accel_y};

  always_comb begin
    dx = '0;
    dy = '0;
    if (BTNR && !BTNL) dx = BSTEP;
    if (BTNL && !BTNR) dx = -BSTEP;
    if (BTND && !BTNU) dy = BSTEP;
    if (BTNU && !BTND) dy = -BSTEP;
  end
`endif

  // 12-bit signed sums so a step below zero still clamps low
  assign nx = clamp($signed({2'b00, px}) + dx, XLO, XHI);
  assign ny = clamp($signed({2'b00, py}) + dy, XLO, YHI);

  assign overlap = near(px, tx) && near(py, ty);

  assign lfsr_nx = {lfsr[14:0],
                    lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  assign cx = lfsr[9:0];
  assign cy = {1'b0, lfsr[15:7]};

  assign accept = (cx >= TLO) && (cx <= TXHI) &&
                  (cy >= TLO) && (cy <= TYHI) &&
                  !(near(px, cx) && near(py, cy));

  // fallback puts the target on the far side of the player
  assign fx = (px < XMID) ? TXHI : TLO;
  assign fy = (py < YMID) ? TYHI : TLO;

  assign give_up = (tries == TW'(MAX_TRIES));

  always_ff @(posedge clk_25mHz) begin
    if (reset) state <= IDLE;
    else state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:     if (frame_tick) next = MOVE;
      MOVE:     next = CHECK;
      CHECK:    next = overlap ? RELOCATE : IDLE;
      RELOCATE: if (give_up || accept) next = IDLE;
      default:  next = IDLE;
    endcase
  end

  always_ff @(posedge clk_25mHz) begin
    if (reset) begin
      px    <= 10'd320;
      py    <= 10'd240;
      tx    <= 10'd120;
      ty    <= 10'd120;
      score <= '0;
      hit   <= 1'b0;
      lfsr  <= 16'hACE1;
      tries <= '0;
    end else begin
      hit <= 1'b0;
      unique case (state)
        MOVE: begin
          px <= nx;
          py <= ny;
        end
        CHECK: begin
          tries <= '0;
          if (overlap) begin
            hit   <= 1'b1;
            score <= score + 16'd1;
          end
        end
        RELOCATE: begin
          lfsr <= lfsr_nx;
          if (give_up) begin
            tx <= fx;
            ty <= fy;
          end else if (accept) begin
            tx <= cx;
            ty <= cy;
          end else begin
            tries <= tries + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign player_x = {22'd0, px};
  assign player_y = {22'd0, py};
  assign target_x = {22'd0, tx};
  assign target_y = {22'd0, ty};
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_player_motion.sv
// tb_player_motion: directed frames against a reference model;
// expected per-frame results flow through a scoreboard queue.
module tb_player_motion;

  logic        clk_25mHz;
  logic        reset;
  logic        frame_tick;
  logic        BTNU, BTNL, BTNR, BTND;
  logic [31:0] accel_x, accel_y;
  logic [31:0] player_x, player_y;
  logic [31:0] target_x, target_y;
  logic [15:0] score;
  logic        hit;
  logic        busy;

  player_motion dut (
    .clk_25mHz (clk_25mHz),
    .reset     (reset),
    .frame_tick(frame_tick),
    .BTNU      (BTNU),
    .BTNL      (BTNL),
    .BTNR      (BTNR),
    .BTND      (BTND),
    .accel_x   (accel_x),
    .accel_y   (accel_y),
    .player_x  (player_x),
    .player_y  (player_y),
    .target_x  (target_x),
    .target_y  (target_y),
    .score     (score),
    .hit       (hit),
    .busy      (busy)
  );

  initial clk_25mHz = 1'b0;
  always #20 clk_25mHz = ~clk_25mHz;

  typedef struct {
    int   px;
    int   py;
    int   sc;
    logic h;
  } exp_t;

  exp_t q[$];

  int tests = 0;
  int fails = 0;
  int mx, my, mtx, mty, msc;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  function automatic int clampi(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int absi(int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic ovl(int ax, int ay, int bx, int by);
    return (absi(ax - bx) < 55) && (absi(ay - by) < 55);
  endfunction

`ifdef TILT_CONTROL_EN
  function automatic int ddx();
    int a;
    a = $signed(accel_x) >>> 4;
    return clampi(a, -8, 8);
  endfunction
  function automatic int ddy();
    int a;
    a = $signed(accel_y) >>> 4;
    return clampi(a, -8, 8);
  endfunction
`else
  function automatic int ddx();
    return (int'(BTNR) - int'(BTNL)) * 4;
  endfunction
  function automatic int ddy();
    return (int'(BTND) - int'(BTNU)) * 4;
  endfunction
`endif

  task automatic model_reset();
    mx = 320; my = 240;
    mtx = 120; mty = 120;
    msc = 0;
    q.delete();
  endtask

  task automatic frame(input logic u, input logic l,
                       input logic r, input logic d);
    exp_t e;
    int ox, cyc;
    BTNU = u; BTNL = l; BTNR = r; BTND = d;
    @(negedge clk_25mHz);
    frame_tick = 1'b1;
    @(negedge clk_25mHz);
    frame_tick = 1'b0;
    ox = mx;
    mx = clampi(mx + ddx(), 25, 614);
    my = clampi(my + ddy(), 25, 454);
    e.h = ovl(mx, my, mtx, mty);
    if (e.h) msc = (msc + 1) & 16'hFFFF;
    e.px = mx; e.py = my; e.sc = msc;
    q.push_back(e);
    check("busy_move", {31'd0, busy}, 32'd1);
    check("px_hold", player_x, ox);
    @(negedge clk_25mHz);
    check("sb_nonempty", q.size(), 1);
    e = q.pop_front();
    check("px", player_x, e.px);
    check("py", player_y, e.py);
    check("hit_early", {31'd0, hit}, 32'd0);
    @(negedge clk_25mHz);
    check("hit", {31'd0, hit}, {31'd0, e.h});
    check("score", {16'd0, score}, e.sc);
    cyc = 2;
    while (busy && cyc < 40) begin
      cyc++;
      @(negedge clk_25mHz);
    end
    check("busy_end", {31'd0, busy}, 32'd0);
    check("busy_len", {31'd0, cyc <= 19}, 32'd1);
    check("hit_once", {31'd0, hit}, 32'd0);
    if (e.h) begin
      check("tx_lo", {31'd0, target_x >= 30}, 32'd1);
      check("tx_hi", {31'd0, target_x <= 609}, 32'd1);
      check("ty_lo", {31'd0, target_y >= 30}, 32'd1);
      check("ty_hi", {31'd0, target_y <= 449}, 32'd1);
      check("t_clear",
            {31'd0, ovl(mx, my, int'(target_x), int'(target_y))},
            32'd0);
    end
  endtask

  task automatic check_reset_state();
    check("rst_px", player_x, 320);
    check("rst_py", player_y, 240);
    check("rst_tx", target_x, 120);
    check("rst_ty", target_y, 120);
    check("rst_score", {16'd0, score}, 0);
    check("rst_hit", {31'd0, hit}, 0);
    check("rst_busy", {31'd0, busy}, 0);
  endtask

  initial begin
    reset = 1'b1;
    frame_tick = 1'b0;
    BTNU = 0; BTNL = 0; BTNR = 0; BTND = 0;
    accel_x = '0; accel_y = '0;
    model_reset();
    repeat (3) @(negedge clk_25mHz);
    reset = 1'b0;
    @(negedge clk_25mHz);
    check_reset_state();

`ifdef TILT_CONTROL_EN
    accel_x = 32'h0000_0040;
    accel_y = 32'hFFFF_FF00;
    repeat (3) frame(0, 0, 0, 0);
    accel_x = 32'h0000_1000;
    accel_y = 32'h0;
    repeat (2) frame(0, 0, 0, 0);
    accel_x = 32'h0;
`endif

    repeat (10) frame(0, 0, 1, 0);
    repeat (66) frame(0, 0, 1, 0);
    repeat (150) frame(1, 1, 0, 0);
    frame(0, 1, 1, 0);
    frame(1, 0, 0, 1);

    // ticks during MOVE and CHECK must be dropped
    BTNU = 0; BTNL = 0; BTNR = 0; BTND = 1;
    @(negedge clk_25mHz);
    frame_tick = 1'b1;
    repeat (3) @(negedge clk_25mHz);
    frame_tick = 1'b0;
    my = clampi(my + ddy(), 25, 454);
    mx = clampi(mx + ddx(), 25, 614);
    repeat (4) @(negedge clk_25mHz);
    check("drop_px", player_x, mx);
    check("drop_py", player_y, my);
    check("drop_busy", {31'd0, busy}, 0);

    repeat (11) frame(0, 0, 1, 1);

    // reset with a coincident tick
    @(negedge clk_25mHz);
    reset = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk_25mHz);
    reset = 1'b0;
    frame_tick = 1'b0;
    model_reset();
    check("rst_tick_busy", {31'd0, busy}, 0);
    @(negedge clk_25mHz);
    check_reset_state();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
